// File: rtl/parking_occupancy_counter.sv
// Parking lot occupancy counter with daily open/closing/closed cycle.
// Tracks cars, daily entries, daily peak, and sticky over/underflow flags.
module parking_occupancy_counter #(
  parameter int CAPACITY = 25,
  parameter int CW       = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter,
  input  logic          exit,
  input  logic          day_end,
  input  logic          day_start,
  output logic [CW-1:0] occupancy,
  output logic          full,
  output logic          empty,
  output logic [7:0]    entries_total,
  output logic [CW-1:0] peak,
  output logic [1:0]    state,
  output logic          overflow_err,
  output logic          underflow_err
);

  localparam logic [CW-1:0] LP_CAP = CW'(CAPACITY);

  typedef enum logic [1:0] {
    S_OPEN    = 2'b00,
    S_CLOSING = 2'b01,
    S_CLOSED  = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_occ;
  logic [CW-1:0] w_occ_nxt;
  logic [7:0]    r_tot;
  logic [7:0]    w_tot_nxt;
  logic [CW-1:0] r_peak;
  logic [CW-1:0] w_peak_nxt;
  logic          r_ovf;
  logic          r_unf;
  logic          w_ovf_nxt;
  logic          w_unf_nxt;

  logic w_open;
  logic w_full;
  logic w_empty;
  logic w_inc;
  logic w_dec;
  logic w_accept;
  logic w_ovf_evt;
  logic w_unf_evt;
  logic w_exit_only;
  logic w_reopen;

  assign w_full   = (r_occ == LP_CAP);
  assign w_empty  = (r_occ == '0);
  assign w_open   = (r_state == S_OPEN);
  assign w_reopen = (r_state == S_CLOSED) & day_start;

  // Outside OPEN an enter is ignored, so a paired exit acts alone.
  assign w_exit_only = exit & (~enter | ~w_open);
  assign w_inc       = w_open & enter & ~exit & ~w_full;
  assign w_dec       = w_exit_only & ~w_empty;
  assign w_accept    = w_open & enter & (exit | ~w_full);
  assign w_ovf_evt   = w_open & enter & ~exit & w_full;
  assign w_unf_evt   = w_exit_only & w_empty;

  // Lot state transitions; closing completes on the registered empty.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_OPEN:    if (day_end)   w_state_nxt = S_CLOSING;
      S_CLOSING: if (w_empty)   w_state_nxt = S_CLOSED;
      S_CLOSED:  if (day_start) w_state_nxt = S_OPEN;
      default:                  w_state_nxt = S_OPEN;
    endcase
  end

  // Next values of counters, peak and sticky flags.
  always_comb begin
    w_occ_nxt  = r_occ;
    w_tot_nxt  = r_tot;
    w_peak_nxt = r_peak;
    w_ovf_nxt  = r_ovf | w_ovf_evt;
    w_unf_nxt  = r_unf | w_unf_evt;
    if (w_inc) w_occ_nxt = r_occ + 1'b1;
    else if (w_dec) w_occ_nxt = r_occ - 1'b1;
    if (w_accept && r_tot != 8'hFF) w_tot_nxt = r_tot + 8'd1;
    if (w_occ_nxt > r_peak) w_peak_nxt = w_occ_nxt;
    if (w_reopen) begin
      w_tot_nxt  = '0;
      w_peak_nxt = '0;
      w_ovf_nxt  = 1'b0;
      w_unf_nxt  = 1'b0;
    end
  end

  // State register with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_OPEN;
      r_occ   <= '0;
      r_tot   <= '0;
      r_peak  <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_occ   <= w_occ_nxt;
      r_tot   <= w_tot_nxt;
      r_peak  <= w_peak_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign occupancy     = r_occ;
  assign full          = w_full;
  assign empty         = w_empty;
  assign entries_total = r_tot;
  assign peak          = r_peak;
  assign state         = r_state;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule

// File: doc/parking_occupancy_counter.md
PARKING_OCCUPANCY_COUNTER -- requirements
Module: parking_occupancy_counter

Parameters
REQ-001 CAPACITY, 25, maximum number of cars the lot holds (1..2^CW-1).
REQ-002 CW, 5, width of occupancy and peak counters.

Interface
REQ-003 clk  input  1  clock; all state changes on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enter  input  1  single-cycle pulse from the upstream entry/exit detector FSM: one car entered.
REQ-006 exit  input  1  single-cycle pulse from the upstream detector: one car left.
REQ-007 day_end  input  1  request to close the lot.
REQ-008 day_start  input  1  request to reopen the lot and clear daily statistics.
REQ-009 occupancy  output  CW  current number of cars, registered.
REQ-010 full  output  1  high iff occupancy == CAPACITY.
REQ-011 empty  output  1  high iff occupancy == 0.
REQ-012 entries_total  output  8  accepted entries since last reset or day_start, saturating at 255.
REQ-013 peak  output  CW  maximum occupancy since last reset or day_start.
REQ-014 state  output  2  OPEN=00, CLOSING=01, CLOSED=10; 11 unused.
REQ-015 overflow_err  output  1  sticky: enter rejected because lot full.
REQ-016 underflow_err  output  1  sticky: exit received while lot empty.

Function
REQ-017 The block SHALL sample enter/exit every posedge; occupancy, entries_total, peak, and error flags SHALL reflect a pulse one cycle after the sampling edge.
REQ-018 In OPEN, enter & ~exit & ~full SHALL increment occupancy and entries_total.
REQ-019 In any state, exit & ~enter & ~empty SHALL decrement occupancy.
REQ-020 enter & exit in the same cycle in OPEN SHALL leave occupancy unchanged, increment entries_total, and set no error flag, including at full or empty.
REQ-021 enter & ~exit while full in OPEN SHALL hold occupancy and set overflow_err.
REQ-022 exit & ~enter while empty SHALL hold occupancy and set underflow_err.
REQ-023 In CLOSING or CLOSED, enter SHALL be ignored: no count change, no error flag. enter & exit together SHALL be treated as exit alone.
REQ-024 entries_total SHALL saturate at 255 and never wrap.
REQ-025 peak SHALL update to the new occupancy whenever the next occupancy exceeds the current peak, in the same cycle as occupancy.
REQ-026 full and empty SHALL be combinational decodes of the occupancy register only.
REQ-027 FSM: OPEN with day_end=1 SHALL go to CLOSING; otherwise it SHALL stay OPEN.
REQ-028 FSM: CLOSING with empty=1 (registered occupancy) SHALL go to CLOSED on the next edge; day_end and day_start SHALL be ignored in CLOSING.
REQ-029 FSM: CLOSED with day_start=1 SHALL go to OPEN and clear entries_total, peak, overflow_err, and underflow_err on that same edge; occupancy SHALL remain unchanged.
REQ-030 day_start in OPEN or CLOSING, and day_end in CLOSING or CLOSED, SHALL have no effect.
REQ-031 day_end with the lot already empty SHALL produce OPEN -> CLOSING -> CLOSED on two consecutive edges.
REQ-032 Error flags SHALL stay set until reset or the day_start reopen.

Reset
REQ-033 reset=1 at a posedge SHALL force state=OPEN, occupancy=0, entries_total=0, peak=0, overflow_err=0, and underflow_err=0.
REQ-034 reset SHALL take priority over all other inputs, including mid-closing and a simultaneous enter or exit.
REQ-035 After reset, outputs SHALL read full=0 and empty=1.

Verification
REQ-036 Reset, then 3 enter pulses, then 1 exit pulse -> occupancy 1,2,3,2; entries_total=3; peak=3; empty=0.
REQ-037 CAPACITY=25: 26 enter pulses -> occupancy=25, full=1, overflow_err=1, entries_total=25; then enter & exit together -> occupancy stays 25, entries_total=26.
REQ-038 From reset, 1 exit pulse -> occupancy=0, underflow_err=1; then 300 enter/exit pairs -> entries_total=255.
REQ-039 occupancy=2, day_end pulse -> state=01; enter pulse ignored (occupancy=2); 2 exit pulses -> occupancy=0; next edge state=10; day_start -> state=00, entries_total=0, peak=0, error flags cleared.
REQ-040 occupancy=4 in CLOSING, reset asserted with a simultaneous exit -> next cycle state=00, occupancy=0, all counters and flags 0.
